if_id_buffer: RTL and testbench

IF_ID_BUFFER -- requirements
Module: ysyx_25060170_if_id

---
 rtl/if_id_buffer.sv | 96 +++++++++
 tb/tb_if_id_buffer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/if_id_buffer.sv
// ============================================================================
// Module      : if_id_buffer
// Description : Two-entry skid FIFO carrying {inst, pc} from fetch to decode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_id_buffer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_valid,
  input  logic [31:0] if_inst,
  input  logic [31:0] if_pc,
  output logic        if_ready,
  input  logic        flush,
  input  logic        id_accept,
  output logic        id_valid,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic [1:0]  occupancy
);

  localparam logic [31:0] C_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        r_wr_ptr;
  logic        r_rd_ptr;
  logic [31:0] r_inst [2];
  logic [31:0] r_pc   [2];
  logic        w_push;
  logic        w_pop;

  // Ready comes from registered state only, so decode cannot stall fetch combinationally.
  assign if_ready  = (r_state != FULL);
  assign id_valid  = (r_state != EMPTY);
  assign occupancy = r_state;

  // A flush cycle neither stores the incoming entry nor retires the head.
  assign w_push = if_valid & if_ready & ~flush;
  assign w_pop  = id_valid & id_accept & ~flush;

  assign id_inst = id_valid ? r_inst[r_rd_ptr] : C_NOP;
  assign id_pc   = id_valid ? r_pc[r_rd_ptr]   : 32'h0000_0000;

  always_comb begin
    w_state_next = r_state;
    if (flush) begin
      w_state_next = EMPTY;
    end else begin
      case (r_state)
        EMPTY:   if (w_push) w_state_next = ONE;
        ONE: begin
          if (w_push && !w_pop)      w_state_next = FULL;
          else if (!w_push && w_pop) w_state_next = EMPTY;
        end
        FULL:    if (w_pop) w_state_next = ONE;
        default: w_state_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= EMPTY;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (flush) begin
        r_wr_ptr <= 1'b0;
        r_rd_ptr <= 1'b0;
      end else begin
        if (w_push) r_wr_ptr <= ~r_wr_ptr;
        if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      end
    end
  end

  // Payload needs no reset: it is only observed through the valid mask.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_inst[r_wr_ptr] <= if_inst;
      r_pc[r_wr_ptr]   <= if_pc;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_if_id_buffer.sv
// ============================================================================
// Module      : tb_if_id_buffer
// Description : Directed vector bench for if_id_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_id_buffer;

  localparam logic [31:0] C_NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        if_ready;
  logic        flush;
  logic        id_accept;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic [1:0]  occupancy;

  if_id_buffer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_valid  (if_valid),
    .if_inst   (if_inst),
    .if_pc     (if_pc),
    .if_ready  (if_ready),
    .flush     (flush),
    .id_accept (id_accept),
    .id_valid  (id_valid),
    .id_inst   (id_inst),
    .id_pc     (id_pc),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs applied in a cycle, and the outputs expected during that same cycle.
  typedef struct {
    logic        v;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        fl;
    logic        acc;
    logic [1:0]  eocc;
    logic        erdy;
    logic        eval;
    logic [31:0] einst;
    logic [31:0] epc;
  } vec_t;

  vec_t vecs[$];
  int   n_tests;
  int   n_fail;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'h5A5A_0000;
  endfunction

  function automatic void add(input logic v, input logic [31:0] pc, input logic fl,
                              input logic acc, input logic [1:0] eocc,
                              input logic [31:0] head_pc);
    vec_t r;
    r.v     = v;
    r.pc    = pc;
    r.inst  = inst_of(pc);
    r.fl    = fl;
    r.acc   = acc;
    r.eocc  = eocc;
    r.erdy  = (eocc != 2'd2);
    r.eval  = (eocc != 2'd0);
    r.einst = r.eval ? inst_of(head_pc) : C_NOP;
    r.epc   = r.eval ? head_pc : 32'h0;
    vecs.push_back(r);
  endfunction

  task automatic check(input string name, input logic [1:0] eocc, input logic erdy,
                       input logic eval, input logic [31:0] einst, input logic [31:0] epc);
    n_tests++;
    if ({occupancy, if_ready, id_valid, id_inst, id_pc} !== {eocc, erdy, eval, einst, epc}) begin
      n_fail++;
      $display("FAIL %s: got occ=%0d rdy=%b val=%b inst=%h pc=%h, want occ=%0d rdy=%b val=%b inst=%h pc=%h",
               name, occupancy, if_ready, id_valid, id_inst, id_pc,
               eocc, erdy, eval, einst, epc);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                       input logic fl, input logic acc);
    if_valid  = v;
    if_inst   = inst;
    if_pc     = pc;
    flush     = fl;
    id_accept = acc;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Single pass with accept held; first vector uses the literal auipc word.
    add(1, 32'h8000_0000, 0, 1, 2'd0, 32'h0);
    vecs[0].inst = 32'h0000_0297;
    add(0, 32'h0, 0, 1, 2'd1, 32'h8000_0000);
    vecs[1].einst = 32'h0000_0297;
    add(0, 32'h0, 0, 0, 2'd0, 32'h0);
    // Fill and stall; third push ignored.
    add(1, 32'h8000_0000, 0, 0, 2'd0, 32'h0);
    add(1, 32'h8000_0004, 0, 0, 2'd1, 32'h8000_0000);
    add(1, 32'h8000_0008, 0, 0, 2'd2, 32'h8000_0000);
    add(0, 32'h0, 0, 1, 2'd2, 32'h8000_0000);
    add(0, 32'h0, 0, 1, 2'd1, 32'h8000_0004);
    add(0, 32'h0, 0, 0, 2'd0, 32'h0);
    // Streaming: one in, one out per cycle.
    for (int k = 0; k < 8; k++)
      add(1, 32'h8000_0000 + 32'(4 * k), 0, 1, (k == 0) ? 2'd0 : 2'd1,
          32'h8000_0000 + 32'(4 * (k - 1)));
    add(0, 32'h0, 0, 1, 2'd1, 32'h8000_001C);
    add(0, 32'h0, 0, 0, 2'd0, 32'h0);
    // Flush while full with push attempt and accept.
    add(1, 32'h8000_0100, 0, 0, 2'd0, 32'h0);
    add(1, 32'h8000_0104, 0, 0, 2'd1, 32'h8000_0100);
    add(1, 32'h8000_0010, 1, 1, 2'd2, 32'h8000_0100);
    add(0, 32'h0, 0, 0, 2'd0, 32'h0);
    // Flush while one entry held and fetch ready: incoming entry discarded.
    add(1, 32'h8000_0200, 0, 0, 2'd0, 32'h0);
    add(1, 32'h8000_0010, 1, 1, 2'd1, 32'h8000_0200);
    add(0, 32'h0, 0, 0, 2'd0, 32'h0);
    add(0, 32'h0, 0, 1, 2'd0, 32'h0);
    // Pointer wrap: push, pop, idle x5.
    for (int j = 0; j < 5; j++) begin
      add(1, 32'h8000_0400 + 32'(4 * j), 0, 0, 2'd0, 32'h0);
      add(0, 32'h0, 0, 1, 2'd1, 32'h8000_0400 + 32'(4 * j));
      add(0, 32'h0, 0, 0, 2'd0, 32'h0);
    end

    #2;
    check("reset_state", 2'd0, 1'b1, 1'b0, C_NOP, 32'h0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].inst, vecs[i].pc, vecs[i].fl, vecs[i].acc);
      #1;
      check($sformatf("vec%0d", i), vecs[i].eocc, vecs[i].erdy, vecs[i].eval,
            vecs[i].einst, vecs[i].epc);
      @(posedge clk); #1;
    end

    // Asynchronous reset while full, then first push right after release.
    drive(1'b1, inst_of(32'h8000_0500), 32'h8000_0500, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(1'b1, inst_of(32'h8000_0504), 32'h8000_0504, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("prefill_full", 2'd2, 1'b0, 1'b1, inst_of(32'h8000_0500), 32'h8000_0500);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", 2'd0, 1'b1, 1'b0, C_NOP, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, inst_of(32'h8000_0600), 32'h8000_0600, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("push_after_reset", 2'd1, 1'b1, 1'b1, inst_of(32'h8000_0600), 32'h8000_0600);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
